// File: rtl/capture_pkg.sv
// Shared constants and the default packed word type for the capture deserialiser.
package capture_pkg;

  localparam int NUM_CH_DEF = 32;
  localparam int DESER_DEF  = 8;
  localparam int SEQ_W      = 16;
  localparam int DROP_W     = 16;

  typedef logic [NUM_CH_DEF-1:0][DESER_DEF-1:0] word_t;

endpackage

// File: rtl/deser_lane.sv
// One capture channel: mask gate plus DESER-bit shift register (bit 0 newest).
module deser_lane #(
  parameter int DESER = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             sample,
  input  logic             mask,
  output logic [DESER-1:0] word_next
);

  logic [DESER-1:0] shift_q;

  // The word including this cycle's sample, so the top can capture it on completion.
  assign word_next = {shift_q[DESER-2:0], sample & mask};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (arm) begin
      shift_q <= word_next;
    end
  end

endmodule

// File: rtl/capture_deser.sv
// Multi-channel capture deserialiser with single-entry output hold and overflow flag.
// Optional build macro CAPTURE_DROP_CNT_EN adds a saturating dropped-word counter.
module capture_deser
  import capture_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DESER  = DESER_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             channels,
  input  logic [NUM_CH-1:0]             ch_mask,
  input  logic                          arm,
  output logic [NUM_CH-1:0][DESER-1:0]  out_data,
  output logic [SEQ_W-1:0]              out_seq,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int PW = (DESER > 1) ? $clog2(DESER) : 1;
  localparam logic [PW-1:0] LAST = PW'(DESER - 1);

  logic [PW-1:0]                 phase;
  logic [SEQ_W-1:0]              seq_cnt;
  logic [NUM_CH-1:0][DESER-1:0]  lane_next;
  logic                          complete;
  logic                          fire;
  logic                          load;
  logic                          drop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    deser_lane #(.DESER(DESER)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .arm       (arm),
      .sample    (channels[i]),
      .mask      (ch_mask[i]),
      .word_next (lane_next[i])
    );
  end

  // Handshake: a word transfers on any edge where out_valid && out_ready; while
  // out_valid=1 and out_ready=0 the producer holds data/seq/valid unchanged.
  // A completing word loads when the holding slot is empty or being emptied now,
  // otherwise it is dropped and the held word survives.
  assign complete = arm && (phase == LAST);
  assign fire     = out_valid && out_ready;
  assign load     = complete && (!out_valid || out_ready);
  assign drop     = complete && out_valid && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (!arm || phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (complete) begin
      seq_cnt <= seq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_seq   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= lane_next;
      out_seq   <= seq_cnt;
      out_valid <= 1'b1;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear wins so no overflow is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr) begin
        drop_cnt <= DROP_W'(1);
      end else if (drop_cnt != {DROP_W{1'b1}}) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_capture_deser.sv
// Self-checking bench for capture_deser: directed scenarios plus random traffic
// against a transaction-level model (sample queue per word, one-deep output slot).
module tb_capture_deser;
  import capture_pkg::*;

  localparam int NC = NUM_CH_DEF;
  localparam int DS = DESER_DEF;
  localparam int W  = NC * DS;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic [NC-1:0] channels;
  logic [NC-1:0] ch_mask;
  logic          arm;
  word_t         out_data;
  logic [15:0]   out_seq;
  logic          out_valid;
  logic          out_ready;
  logic          ovf;
  logic          ovf_clr;
  logic [15:0]   drop_cnt;

  capture_deser #(.NUM_CH(NC), .DESER(DS)) dut (
    .clk       (clk),
    .rst       (rst),
    .channels  (channels),
    .ch_mask   (ch_mask),
    .arm       (arm),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NC-1:0] smp_q[$];
  logic          m_valid;
  word_t         m_data;
  int            m_seq;
  int            m_cnt;
  logic          m_ovf;
  int            m_drop;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    smp_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_seq   = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT sampled.
  task automatic model_edge();
    logic  fire;
    logic  dropped;
    word_t w;
    fire    = m_valid && out_ready;
    dropped = 1'b0;
    if (arm) begin
      smp_q.push_back(channels & ch_mask);
      if (smp_q.size() == DS) begin
        w = '0;
        for (int k = 0; k < DS; k++)
          for (int c = 0; c < NC; c++)
            w[c][DS-1-k] = smp_q[k][c];
        smp_q.delete();
        if (!m_valid || out_ready) begin
          m_valid = 1'b1;
          m_data  = w;
          m_seq   = m_cnt;
        end else begin
          dropped = 1'b1;
          m_ovf   = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        m_cnt = (m_cnt + 1) % 65536;
      end else if (fire) begin
        m_valid = 1'b0;
      end
    end else begin
      smp_q.delete();
      if (fire) m_valid = 1'b0;
    end
    if (ovf_clr) begin
      if (!dropped) m_ovf = 1'b0;
      m_drop = dropped ? 1 : 0;
    end
  endtask

  function automatic int exp_drop();
`ifdef CAPTURE_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic check_all();
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("out_data",  W'(out_data),  W'(m_data));
    chk("out_seq",   W'(out_seq),   W'(m_seq[15:0]));
    chk("ovf",       W'(ovf),       W'(m_ovf));
    chk("drop_cnt",  W'(drop_cnt),  W'(exp_drop()));
  endtask

  // driver: advance one clock, update model, check 1 time unit after the edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive_pattern(input logic [DS-1:0] pat);
    for (int i = 0; i < DS; i++) begin
      channels    = NC'($urandom);
      channels[0] = pat[DS-1-i];
      cycle();
    end
  endtask

  logic [DS-1:0] pat;
  int            held_seq;

  initial begin
    rst       = 1'b1;
    channels  = '0;
    ch_mask   = '0;
    arm       = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // basic capture
    ch_mask   = '1;
    out_ready = 1'b1;
    arm       = 1'b1;
    pat       = 8'b10110010;
    drive_pattern(pat);
    chk("basic_valid", W'(out_valid), W'(1'b1));
    chk("basic_ch0",   W'(out_data[0]), W'(pat));
    chk("basic_seq",   W'(out_seq), W'(16'd0));
    arm = 1'b0;
    cycle();
    cycle();

    // masking
    ch_mask  = 32'hFFFF_FFFE;
    channels = '1;
    arm      = 1'b1;
    for (int i = 0; i < DS; i++) cycle();
    chk("mask_ch0", W'(out_data[0]), W'(8'h00));
    for (int c = 1; c < NC; c++) chk("mask_chN", W'(out_data[c]), W'(8'hFF));
    arm = 1'b0;
    cycle();
    cycle();

    // backpressure
    ch_mask   = '1;
    out_ready = 1'b0;
    arm       = 1'b1;
    held_seq  = m_cnt;
    for (int i = 0; i < 2 * DS; i++) begin
      channels = NC'($urandom);
      cycle();
    end
    chk("bp_seq",  W'(out_seq), W'(held_seq[15:0]));
    chk("bp_ovf",  W'(ovf), W'(1'b1));
`ifdef CAPTURE_DROP_CNT_EN
    chk("bp_drop", W'(drop_cnt), W'(16'd1));
`else
    chk("bp_drop", W'(drop_cnt), W'(16'd0));
`endif
    out_ready = 1'b1;
    for (int i = 0; i < DS; i++) begin
      channels = NC'($urandom);
      cycle();
    end
    chk("bp_next_seq", W'(out_seq), W'(16'(held_seq + 2)));
    arm     = 1'b0;
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("bp_clr_ovf", W'(ovf), W'(1'b0));
    cycle();

    // handshake in the completion cycle
    out_ready = 1'b0;
    arm       = 1'b1;
    for (int i = 0; i < 2 * DS - 1; i++) begin
      channels = NC'($urandom);
      cycle();
    end
    held_seq  = int'(out_seq);
    out_ready = 1'b1;
    channels  = NC'($urandom);
    cycle();
    chk("sim_valid", W'(out_valid), W'(1'b1));
    chk("sim_seq",   W'(out_seq), W'(16'(held_seq + 1)));
    chk("sim_ovf",   W'(ovf), W'(1'b0));
    arm = 1'b0;
    cycle();
    cycle();

    // disarm at phase 5 then re-arm
    arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      channels = NC'($urandom);
      cycle();
    end
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      channels = NC'($urandom);
      cycle();
      chk("disarm_novalid", W'(out_valid), W'(1'b0));
    end
    arm = 1'b1;
    pat = 8'($urandom);
    drive_pattern(pat);
    chk("rearm_valid", W'(out_valid), W'(1'b1));
    chk("rearm_ch0",   W'(out_data[0]), W'(pat));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      arm       = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      channels  = NC'($urandom);
      if ($urandom_range(0, 15) == 0) ch_mask = NC'($urandom);
      cycle();
    end

    // asynchronous reset while a word is held and ovf is set
    arm       = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b0;
    cycle();
    arm = 1'b1;
    for (int i = 0; i < 2 * DS + 3; i++) begin
      channels = NC'($urandom);
      cycle();
    end
    chk("pre_rst_valid", W'(out_valid), W'(1'b1));
    chk("pre_rst_ovf",   W'(ovf), W'(1'b1));
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_valid", W'(out_valid), W'(1'b0));
    chk("rst_ovf",   W'(ovf), W'(1'b0));
    chk("rst_seq",   W'(out_seq), W'(16'd0));
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    arm = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
